logic_sweep_ctrl: RTL and testbench



---
 rtl/logic_sweep_ctrl.sv | 151 +++++++++++++++
 tb/tb_logic_sweep_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: self-test sequencer for a 4-input/2-output combinational block.
// On start, drives vectors 0..15 in ascending order. Each vector is held for SETTLE_CYCLES
// cycles and then sampled for one cycle. The sampled X/Y values are compared against the
// expected truth tables, and the sequencer reports pass, error count and first failing vector.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   start       level-sampled sweep request (acted on only in idle)
//   x_in, y_in  outputs of the logic block under test
//   vec_out     registered drive vector {A,B,C,D}
//   busy        high while a sweep is in progress
//   done        one-cycle pulse when a sweep completes
//   pass        sweep finished with zero mismatches; held until next accepted start
//   err_count   number of mismatching vectors (0..16)
//   fail_valid  at least one mismatch seen
//   first_fail  index of the first mismatching vector (valid when fail_valid=1)
module logic_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,        // legal range 1..15
  parameter logic [15:0] EXP_X         = 16'hCF00, // bit i = expected X for vector i
  parameter logic [15:0] EXP_Y         = 16'h5CFC  // bit i = expected Y for vector i
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       x_in,
  input  logic       y_in,
  output logic [3:0] vec_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] first_fail
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  // Counter value seen on the last settle cycle of a vector.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       fail_valid_q, fail_valid_d;
  logic [3:0] first_fail_q, first_fail_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
  logic       mismatch;

  // A vector with both outputs wrong still counts as a single mismatch.
  assign mismatch = (x_in != EXP_X[vec_q]) || (y_in != EXP_Y[vec_q]);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StDrive;
          vec_d        = 4'd0;
          cnt_d        = 4'd0;
          err_d        = 5'd0;
          fail_valid_d = 1'b0;
          first_fail_d = 4'd0;
          pass_d       = 1'b0;
        end
      end

      StDrive: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end
      end

      StSample: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = vec_q;
          end
        end
        if (vec_q != 4'd15) begin
          vec_d   = vec_q + 4'd1;
          cnt_d   = 4'd0;
          state_d = StDrive;
        end else begin
          // Last vector: verdict includes this final sample.
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_d == 5'd0);
        end
      end

      StDone: begin
        vec_d   = 4'd0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      vec_q        <= 4'd0;
      cnt_q        <= 4'd0;
      err_q        <= 5'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 4'd0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = (state_q == StDrive) || (state_q == StSample);
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl. Unit 0 uses SETTLE_CYCLES=1 and unit 1 uses SETTLE_CYCLES=3.
// A behavioural block under test (golden equations plus selectable faults) answers vec_out.
// Expected sweep results are pushed to a scoreboard queue at start and popped at done.
module tb_logic_sweep_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] err;
    logic       fv;
    logic [3:0] ff;
    logic       pass;
  } res_t;

  logic [1:0]      reset_v;
  logic [1:0]      start_v;
  logic [1:0]      x_v, y_v;
  logic [1:0][3:0] vec_v;
  logic [1:0]      busy_v, done_v, pass_v, fv_v;
  logic [1:0][4:0] err_v;
  logic [1:0][3:0] ff_v;
  int              mode_s [2];

  int   checks   = 0;
  int   failures = 0;
  res_t sb_q[$];

  // Reference equations of the lab block.
  function automatic logic gold_x(logic [3:0] v);
    return v[3] & (~v[2] | v[1]);
  endfunction

  function automatic logic gold_y(logic [3:0] v);
    return (~v[2] & v[1]) | (~(v[3] & v[0]) & (v[2] | v[1]));
  endfunction

  // Modes: 0 golden, 1 X stuck at 0, 2 Y wrong at 13 and both wrong at 15, 3 X stuck at 1.
  function automatic logic blk_x(logic [3:0] v, int m);
    case (m)
      1:       return 1'b0;
      2:       return (v == 4'd15) ? ~gold_x(v) : gold_x(v);
      3:       return 1'b1;
      default: return gold_x(v);
    endcase
  endfunction

  function automatic logic blk_y(logic [3:0] v, int m);
    if (m == 2 && (v == 4'd13 || v == 4'd15)) return ~gold_y(v);
    return gold_y(v);
  endfunction

  function automatic res_t model(int m);
    res_t r;
    logic [3:0] v;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      if (blk_x(v, m) !== gold_x(v) || blk_y(v, m) !== gold_y(v)) begin
        if (!r.fv) begin
          r.fv = 1'b1;
          r.ff = v;
        end
        r.err = r.err + 5'd1;
      end
    end
    r.pass = (r.err == 5'd0);
    return r;
  endfunction

  assign x_v[0] = blk_x(vec_v[0], mode_s[0]);
  assign y_v[0] = blk_y(vec_v[0], mode_s[0]);
  assign x_v[1] = blk_x(vec_v[1], mode_s[1]);
  assign y_v[1] = blk_y(vec_v[1], mode_s[1]);

  logic_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_s1 (
    .clock     (clock),
    .reset     (reset_v[0]),
    .start     (start_v[0]),
    .x_in      (x_v[0]),
    .y_in      (y_v[0]),
    .vec_out   (vec_v[0]),
    .busy      (busy_v[0]),
    .done      (done_v[0]),
    .pass      (pass_v[0]),
    .err_count (err_v[0]),
    .fail_valid(fv_v[0]),
    .first_fail(ff_v[0])
  );

  logic_sweep_ctrl #(.SETTLE_CYCLES(3)) dut_s3 (
    .clock     (clock),
    .reset     (reset_v[1]),
    .start     (start_v[1]),
    .x_in      (x_v[1]),
    .y_in      (y_v[1]),
    .vec_out   (vec_v[1]),
    .busy      (busy_v[1]),
    .done      (done_v[1]),
    .pass      (pass_v[1]),
    .err_count (err_v[1]),
    .fail_valid(fv_v[1]),
    .first_fail(ff_v[1])
  );

  task automatic test_reset;
    reset_v = 2'b11;
    start_v = 2'b00;
    repeat (2) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (vec_v[u] !== 4'd0 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 ||
          pass_v[u] !== 1'b0 || err_v[u] !== 5'd0 || fv_v[u] !== 1'b0 || ff_v[u] !== 4'd0) begin
        failures++;
        $display("FAIL reset_state u%0d: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d fv=%0b ff=%0d, want all 0",
                 u, vec_v[u], busy_v[u], done_v[u], pass_v[u], err_v[u], fv_v[u], ff_v[u]);
      end
    end
    reset_v = 2'b00;
    @(negedge clock);
  endtask

  // One sweep on unit u with block mode m. pulse_at: timeline cycle at which start is pulsed
  // mid-sweep (-1 none). abort_at: timeline cycle at which reset is applied (-1 none).
  task automatic run_sweep(input int u, input int m, input int pulse_at, input int abort_at,
                           input string name);
    int   s;
    int   n;
    res_t r;
    logic [3:0] want_vec;
    logic saw_done;
    s = (u == 1) ? 3 : 1;
    n = 16 * (s + 1);
    mode_s[u] = m;
    @(negedge clock);
    start_v[u] = 1'b1;
    sb_q.push_back(model(m));
    @(negedge clock);
    start_v[u] = 1'b0;
    checks++;
    if (err_v[u] !== 5'd0 || fv_v[u] !== 1'b0 || pass_v[u] !== 1'b0 || ff_v[u] !== 4'd0) begin
      failures++;
      $display("FAIL %s_cleared: got err=%0d fv=%0b pass=%0b ff=%0d, want all 0",
               name, err_v[u], fv_v[u], pass_v[u], ff_v[u]);
    end
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        reset_v[u] = 1'b1;
        @(negedge clock);
        reset_v[u] = 1'b0;
        checks++;
        if (vec_v[u] !== 4'd0 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 ||
            pass_v[u] !== 1'b0 || err_v[u] !== 5'd0 || fv_v[u] !== 1'b0 || ff_v[u] !== 4'd0) begin
          failures++;
          $display("FAIL %s_abort_state: got vec=%0d busy=%0b done=%0b err=%0d fv=%0b, want all 0",
                   name, vec_v[u], busy_v[u], done_v[u], err_v[u], fv_v[u]);
        end
        void'(sb_q.pop_back());
        saw_done = 1'b0;
        for (int j = 0; j < n; j++) begin
          if (done_v[u] === 1'b1 || busy_v[u] !== 1'b0) saw_done = 1'b1;
          @(negedge clock);
        end
        checks++;
        if (saw_done !== 1'b0) begin
          failures++;
          $display("FAIL %s_no_done: got activity=%0b after abort, want 0", name, saw_done);
        end
        return;
      end
      want_vec = 4'(k / (s + 1));
      checks++;
      if (vec_v[u] !== want_vec || busy_v[u] !== 1'b1 || done_v[u] !== 1'b0) begin
        failures++;
        $display("FAIL %s_timeline k=%0d: got vec=%0d busy=%0b done=%0b, want vec=%0d busy=1 done=0",
                 name, k, vec_v[u], busy_v[u], done_v[u], want_vec);
      end
      start_v[u] = (k == pulse_at);
      @(negedge clock);
    end
    start_v[u] = 1'b0;
    checks++;
    if (done_v[u] !== 1'b1 || busy_v[u] !== 1'b0 || vec_v[u] !== 4'd15) begin
      failures++;
      $display("FAIL %s_done_pulse: got done=%0b busy=%0b vec=%0d, want done=1 busy=0 vec=15",
               name, done_v[u], busy_v[u], vec_v[u]);
    end
    r = sb_q.pop_front();
    checks++;
    if (err_v[u] !== r.err || fv_v[u] !== r.fv || pass_v[u] !== r.pass ||
        (r.fv && ff_v[u] !== r.ff)) begin
      failures++;
      $display("FAIL %s_result: got err=%0d fv=%0b ff=%0d pass=%0b, want err=%0d fv=%0b ff=%0d pass=%0b",
               name, err_v[u], fv_v[u], ff_v[u], pass_v[u], r.err, r.fv, r.ff, r.pass);
    end
    @(negedge clock);
    checks++;
    if (done_v[u] !== 1'b0 || busy_v[u] !== 1'b0 || vec_v[u] !== 4'd0 ||
        err_v[u] !== r.err || pass_v[u] !== r.pass) begin
      failures++;
      $display("FAIL %s_hold: got done=%0b busy=%0b vec=%0d err=%0d pass=%0b, want 0 0 0 %0d %0b",
               name, done_v[u], busy_v[u], vec_v[u], err_v[u], pass_v[u], r.err, r.pass);
    end
  endtask

  task automatic test_golden;
    run_sweep(0, 0, -1, -1, "golden");
  endtask

  task automatic test_x_stuck0;
    run_sweep(0, 1, -1, -1, "x_stuck0");
  endtask

  task automatic test_selective_fault;
    run_sweep(0, 2, -1, -1, "selective");
  endtask

  task automatic test_settle3;
    run_sweep(1, 0, 20, -1, "settle3");
  endtask

  task automatic test_reset_mid;
    // Vector 6 first DRIVE cycle with SETTLE_CYCLES=1 is timeline cycle 12.
    run_sweep(0, 0, -1, 12, "reset_mid");
    run_sweep(0, 0, -1, -1, "after_reset");
  endtask

  task automatic test_back_to_back;
    int   cyc;
    int   gap;
    res_t r;
    mode_s[0] = 3;
    @(negedge clock);
    start_v[0] = 1'b1;
    sb_q.push_back(model(3));
    sb_q.push_back(model(3));
    cyc = 0;
    while (done_v[0] !== 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clock);
    end
    checks++;
    if (cyc != 33) begin
      failures++;
      $display("FAIL b2b_first_done: got done after %0d negedges, want 33", cyc);
    end
    r = sb_q.pop_front();
    checks++;
    if (err_v[0] !== r.err || ff_v[0] !== r.ff || fv_v[0] !== r.fv || pass_v[0] !== r.pass) begin
      failures++;
      $display("FAIL b2b_first_result: got err=%0d ff=%0d fv=%0b pass=%0b, want %0d %0d %0b %0b",
               err_v[0], ff_v[0], fv_v[0], pass_v[0], r.err, r.ff, r.fv, r.pass);
    end
    gap = 0;
    @(negedge clock);
    while (done_v[0] !== 1'b1 && gap < 100) begin
      gap++;
      if (gap == 2) begin
        checks++;
        if (busy_v[0] !== 1'b1 || err_v[0] !== 5'd0 || fv_v[0] !== 1'b0 || pass_v[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_restart_clear: got busy=%0b err=%0d fv=%0b pass=%0b, want 1 0 0 0",
                   busy_v[0], err_v[0], fv_v[0], pass_v[0]);
        end
      end
      @(negedge clock);
    end
    start_v[0] = 1'b0;
    // Cycles with done low strictly between the two pulses.
    checks++;
    if (gap != 16 * (1 + 1) + 1) begin
      failures++;
      $display("FAIL b2b_gap: got %0d cycles between done pulses, want %0d", gap, 16 * 2 + 1);
    end
    r = sb_q.pop_front();
    checks++;
    if (err_v[0] !== 5'd10 || ff_v[0] !== 4'd0 || fv_v[0] !== 1'b1 || pass_v[0] !== 1'b0 ||
        err_v[0] !== r.err) begin
      failures++;
      $display("FAIL b2b_second_result: got err=%0d ff=%0d fv=%0b pass=%0b, want 10 0 1 0",
               err_v[0], ff_v[0], fv_v[0], pass_v[0]);
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    mode_s[0] = 0;
    mode_s[1] = 0;
    test_reset();
    test_golden();
    test_x_stuck0();
    test_selective_fault();
    test_settle3();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
